// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter (fetch read-only, MEM stage read/write)
//               in front of one fixed-latency single-port main memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        d_stall,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic             owner_d_q,  owner_d_d;   // 1 = MEM stage owns the access
  logic             wr_q,       wr_d;
  logic [15:0]      addr_q,     addr_d;
  logic [15:0]      wdata_q,    wdata_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [STV_W-1:0] starve_q,   starve_d;
  logic [15:0]      if_rdata_q, if_rdata_d;
  logic [15:0]      d_rdata_q,  d_rdata_d;
  logic             if_ack_q,   if_ack_d;
  logic             d_ack_q,    d_ack_d;

  logic             grant_fetch;

  // Fetch wins only when data is absent or fetch has already waited STARVE_MAX grants.
  assign grant_fetch = if_req && (!d_req || (starve_q == STV_MAX));

  always_comb begin
    state_d    = state_q;
    owner_d_d  = owner_d_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
          if (grant_fetch) begin
            owner_d_d = 1'b0;
            wr_d      = 1'b0;
            addr_d    = if_addr;
            starve_d  = '0;
          end else begin
            owner_d_d = 1'b1;
            wr_d      = d_wr;
            addr_d    = d_addr;
            wdata_d   = d_wdata;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != STV_MAX) begin
              starve_d = starve_q + STV_W'(1);
            end
          end
        end
      end

      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          if (owner_d_q) begin
            d_ack_d = 1'b1;
            if (!wr_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_d_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_d_q  <= owner_d_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end

  assign mem_enable = (state_q == S_ACCESS);
  assign mem_wr     = (state_q == S_ACCESS) && wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_stall = if_req & ~if_ack_q;
  assign d_stall  = d_req & ~d_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int MEM_LAT    = 4;
  localparam int STARVE_MAX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        d_stall;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] pmem [0:65535] = '{default: 16'h0000};
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [15:0] bd_data = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = pmem[mem_addr];

  always @(posedge clk) begin
    if (bd_we) pmem[bd_addr] <= bd_data;
    else if (mem_enable && mem_wr) pmem[mem_addr] <= mem_wdata;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issues one request from idle, waits for its ack, then lets RESP retire.
  task automatic run_one(input logic d, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, output int lat, output int en_cnt,
                         output int wr_cnt, output int other);
    lat = 0; en_cnt = 0; wr_cnt = 0; other = 0;
    if (d) begin d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata; end
    else   begin if_req = 1'b1; if_addr = addr; end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      en_cnt += int'(mem_enable);
      wr_cnt += int'(mem_wr);
      if (d ? if_ack : d_ack) other++;
      if (d ? d_ack : if_ack) begin lat = n; break; end
    end
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] refm [16];
  int          lat, en, wc, oth, dack_at, iack_at, overlap, nacks, dacks;
  string       order;

  // Transaction-level reference state for the random phase
  int          k, ng, gk, starve;
  logic        busy, m_own_d, m_wr, e_en, e_ack;
  logic [3:0]  m_idx;
  logic [15:0] m_rd, exp_if_rd, exp_d_rd;

  initial begin
    vecs[0] = '{d:1'b0, wr:1'b0, addr:16'h0010, wdata:16'h0000, exp_rdata:16'hBEEF};
    vecs[1] = '{d:1'b1, wr:1'b1, addr:16'h0020, wdata:16'h1234, exp_rdata:16'h0000};
    vecs[2] = '{d:1'b1, wr:1'b0, addr:16'h0020, wdata:16'h0000, exp_rdata:16'h1234};
    vecs[3] = '{d:1'b0, wr:1'b0, addr:16'h0020, wdata:16'h0000, exp_rdata:16'h1234};
    vecs[4] = '{d:1'b1, wr:1'b1, addr:16'hFFFF, wdata:16'hA5A5, exp_rdata:16'h0000};
    vecs[5] = '{d:1'b0, wr:1'b0, addr:16'hFFFF, wdata:16'h0000, exp_rdata:16'hA5A5};
    vecs[6] = '{d:1'b1, wr:1'b0, addr:16'h0000, wdata:16'h0000, exp_rdata:16'h0000};
    vecs[7] = '{d:1'b0, wr:1'b0, addr:16'h0010, wdata:16'h0000, exp_rdata:16'hBEEF};

    @(negedge clk);
    preload(16'h0010, 16'hBEEF);
    for (int i = 0; i < 16; i++) begin
      refm[i] = 16'($urandom);
      preload(16'h0100 + 16'(i), refm[i]);
    end

    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, en, wc, oth);
      check("vec_ack_latency", lat, MEM_LAT + 1);
      check("vec_enable_cycles", en, MEM_LAT);
      check("vec_write_cycles", wc, vecs[i].wr ? MEM_LAT : 0);
      check("vec_other_ack", oth, 0);
      if (vecs[i].wr) check("vec_mem_written", pmem[vecs[i].addr], vecs[i].wdata);
      else check("vec_rdata", vecs[i].d ? d_rdata : if_rdata, vecs[i].exp_rdata);
    end

    // Simultaneous requests: data first, fetch MEM_LAT+2 cycles later
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    if_req = 1'b1; if_addr = 16'h0020;
    dack_at = 0; iack_at = 0; overlap = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("both_if_stall", if_stall, 1);
        check("both_d_stall", d_stall, 1);
      end
      if (d_ack && if_ack) overlap++;
      if (d_ack) begin
        dack_at = n; d_req = 1'b0;
        check("both_d_stall_at_ack", d_stall, 0);
        check("both_if_stall_at_dack", if_stall, 1);
      end
      if (if_ack) begin iack_at = n; if_req = 1'b0; break; end
    end
    check("both_d_ack_time", dack_at, MEM_LAT + 1);
    check("both_if_ack_time", iack_at, 2 * MEM_LAT + 3);
    check("both_overlap", overlap, 0);
    check("both_d_rdata", d_rdata, 16'hBEEF);
    check("both_if_rdata", if_rdata, 16'h1234);
    @(negedge clk);

    // Starvation pattern with both requests held
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
    if_req = 1'b1; if_addr = 16'h0010;
    order = ""; nacks = 0;
    for (int n = 0; n < 100 && nacks < 6; n++) begin
      @(negedge clk);
      if (d_ack)  begin order = {order, "D"}; nacks++; end
      if (if_ack) begin order = {order, "F"}; nacks++; end
    end
    d_req = 1'b0; if_req = 1'b0;
    checks++;
    if (order != "DDFDDF") begin
      errors++;
      $display("FAIL starve_order actual=%s expected=DDFDDF", order);
    end
    @(negedge clk); @(negedge clk);

    // Data request dropped mid-access still completes once
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5A5A;
    @(negedge clk); @(negedge clk);
    d_req = 1'b0;
    dack_at = 0; iack_at = 0; dacks = 0;
    for (int n = 3; n <= 20; n++) begin
      @(negedge clk);
      if (d_ack) begin dacks++; dack_at = n; if_req = 1'b1; if_addr = 16'h0030; break; end
    end
    check("drop_d_ack_time", dack_at, MEM_LAT + 1);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (d_ack) dacks++;
      if (if_ack) begin iack_at = n; if_req = 1'b0; break; end
    end
    check("drop_d_ack_count", dacks, 1);
    check("drop_next_grant", iack_at, MEM_LAT + 2);
    check("drop_if_rdata", if_rdata, 16'h5A5A);
    check("drop_mem_written", pmem[16'h0030], 16'h5A5A);
    @(negedge clk);

    // Asynchronous reset in the middle of an access
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h7777;
    @(negedge clk); @(negedge clk);
    check("arst_enable_before", mem_enable, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_enable_drop", mem_enable, 0);
    check("arst_wr_drop", mem_wr, 0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nacks = 0; en = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (d_ack || if_ack) nacks++;
      en += int'(mem_enable);
    end
    check("arst_no_ack", nacks, 0);
    check("arst_port_idle", en, 0);
    check("arst_d_rdata", d_rdata, 0);
    run_one(1'b0, 1'b0, 16'h0010, 16'h0000, lat, en, wc, oth);
    check("arst_post_latency", lat, MEM_LAT + 1);
    check("arst_post_rdata", if_rdata, 16'hBEEF);

    // Randomised traffic against a transaction-level model
    k = 0; ng = 1; gk = 0; starve = 0; busy = 1'b0;
    m_own_d = 1'b0; m_wr = 1'b0; m_idx = '0; m_rd = '0;
    exp_if_rd = 16'hBEEF; exp_d_rd = 16'h0000;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      k++;
      if (!busy && k >= ng && (if_req || d_req)) begin
        m_own_d = d_req && !(if_req && starve == STARVE_MAX);
        if (m_own_d) begin
          starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
          m_wr = d_wr; m_idx = d_addr[3:0];
          if (d_wr) refm[m_idx] = d_wdata;
          else m_rd = refm[m_idx];
        end else begin
          starve = 0; m_wr = 1'b0; m_idx = if_addr[3:0];
          m_rd = refm[m_idx];
        end
        busy = 1'b1; gk = k;
      end
      @(negedge clk);
      e_en  = busy && (k >= gk) && (k < gk + MEM_LAT);
      e_ack = busy && (k == gk + MEM_LAT);
      check("rnd_mem_enable", mem_enable, e_en);
      check("rnd_mem_wr", mem_wr, e_en && m_wr);
      if (e_en) check("rnd_mem_addr", mem_addr, 16'h0100 + 16'(m_idx));
      check("rnd_if_ack", if_ack, e_ack && !m_own_d);
      check("rnd_d_ack", d_ack, e_ack && m_own_d);
      if (e_ack) begin
        if (!m_wr) begin
          if (m_own_d) exp_d_rd = m_rd;
          else exp_if_rd = m_rd;
        end
        busy = 1'b0; ng = k + 2;
      end
      check("rnd_if_rdata", if_rdata, exp_if_rd);
      check("rnd_d_rdata", d_rdata, exp_d_rd);

      if (!if_req || if_ack) begin
        if ($urandom_range(0, 2) != 0) begin
          if_req = 1'b1; if_addr = 16'h0100 + 16'($urandom_range(0, 15));
        end else begin
          if_req = 1'b0;
        end
      end
      if (!d_req || d_ack) begin
        if ($urandom_range(0, 2) != 0) begin
          d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
          d_addr = 16'h0100 + 16'($urandom_range(0, 15));
          d_wdata = 16'($urandom);
        end else begin
          d_req = 1'b0;
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
